// File: rtl/cipher_sequencer.sv
// Encryption control sequencer: latches key/modulus, streams a plaintext block
// through the additive cipher into the ciphertext BRAM and reports progress.
module cipher_sequencer #(
  parameter int unsigned LEN    = 30,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK100MHZ,
  input  logic              resetn,
  input  logic              start,
  input  logic              key_valid,
  input  logic [7:0]        ekey,
  input  logic [7:0]        mod,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       progress
);

  localparam int unsigned PROD_W = ADDR_W + 4;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY, S_CALC, S_RUN, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t            state, state_n;
  logic [7:0]        key_q, key_n;
  logic [7:0]        mod_q, mod_n;
  logic [7:0]        off_q, off_n;
  logic              rd_en_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              clear;
  logic              busy_n, done_n, err_n;

  // Read-return pipeline and write bookkeeping
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] written_n;
  logic [PROD_W-1:0] fill;
  logic [4:0]        fill_cnt;
  logic [15:0]       prog_n;

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      key_q <= '0;
      mod_q <= '0;
      off_q <= '0;
    end else begin
      state <= state_n;
      key_q <= key_n;
      mod_q <= mod_n;
      off_q <= off_n;
    end
  end

  always_comb begin
    state_n   = state;
    key_n     = key_q;
    mod_n     = mod_q;
    off_n     = off_q;
    rd_en_n   = 1'b0;
    rd_addr_n = rd_addr;
    clear     = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_n   = S_KEY;
          clear     = 1'b1;
          rd_addr_n = '0;
        end
      end
      S_KEY: begin
        if (key_valid) begin
          key_n   = ekey;
          mod_n   = mod;
          state_n = S_CALC;
        end
      end
      S_CALC: begin
        if (mod_q == 8'd0) begin
          state_n = S_ERR;
        end else begin
          off_n     = key_q % mod_q;
          state_n   = S_RUN;
          rd_en_n   = 1'b1;
          rd_addr_n = '0;
        end
      end
      S_RUN: begin
        if (rd_addr == LAST_ADDR) begin
          state_n = S_DRAIN;
        end else begin
          rd_en_n   = 1'b1;
          rd_addr_n = rd_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Last write is visible on the registered outputs this cycle
        if (wr_en && (wr_addr == LAST_ADDR)) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_KEY) || (state_n == S_CALC) ||
             (state_n == S_RUN) || (state_n == S_DRAIN);
    done_n = (state_n == S_DONE);
    err_n  = (state_n == S_ERR);
  end

  // Thermometer fill for the write that is about to be issued
  always_comb begin
    written_n = wr_cnt + ADDR_W'(1);
    fill      = {written_n, 4'b0000} / PROD_W'(LEN);
    fill_cnt  = 5'(fill);
    prog_n    = '0;
    for (int i = 0; i < 16; i++) begin
      prog_n[i] = (5'(i) < fill_cnt);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge resetn) begin
    if (!resetn) begin
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_vld   <= 1'b0;
      rd_idx   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_cnt   <= '0;
      progress <= '0;
    end else begin
      rd_en   <= rd_en_n;
      rd_addr <= rd_addr_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
      rd_vld  <= rd_en;
      rd_idx  <= rd_addr;
      wr_en   <= rd_vld;
      if (rd_vld) begin
        wr_addr <= rd_idx;
        wr_data <= rd_data + off_q;
      end
      if (clear) begin
        wr_cnt   <= '0;
        progress <= '0;
      end else if (rd_vld) begin
        wr_cnt   <= written_n;
        progress <= prog_n;
      end
    end
  end

endmodule

// File: tb/tb_cipher_sequencer.sv
// Scoreboard bench for cipher_sequencer: expected writes queued at start,
// checked as the DUT issues them, plus per-scenario timing checks.
module tb_cipher_sequencer;

  localparam int unsigned LEN    = 30;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              key_valid;
  logic [7:0]        ekey;
  logic [7:0]        mod;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [15:0]       progress;

  cipher_sequencer #(.LEN(LEN), .ADDR_W(ADDR_W)) dut (
    .CLK100MHZ(clk), .resetn(resetn), .start(start), .key_valid(key_valid),
    .ekey(ekey), .mod(mod), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .progress(progress)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Plaintext BRAM, one-cycle read latency
  logic [7:0] mem [0:255];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t e_m;

  int total = 0;
  int bad   = 0;
  int rd_cnt, wr_cnt, first_rd, first_wr, last_wr, done_t, t0;
  logic done_d = 1'b0;
  logic [7:0] got [0:255];

  function automatic logic [15:0] therm(input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i] = (i < n);
    return v;
  endfunction

  // Monitor: scoreboard pops and progress checks on every write
  always @(negedge clk) begin
    if (rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (wr_en) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      got[wr_addr] = wr_data;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got write addr=%0d data=%0d, required none", wr_addr, wr_data);
      end else begin
        e_m = sb.pop_front();
        if (wr_addr !== e_m.addr || wr_data !== e_m.data) begin
          bad++;
          $display("FAIL sb_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   wr_addr, wr_data, e_m.addr, e_m.data);
        end
      end
      total++;
      if (progress !== therm((16 * wr_cnt) / LEN)) begin
        bad++;
        $display("FAIL progress_step: got %h, required %h after %0d writes",
                 progress, therm((16 * wr_cnt) / LEN), wr_cnt);
      end
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL write_busy: got busy=%b, required 1 during write", busy);
      end
    end
    if (done && !done_d && done_t < 0) done_t = cyc;
    done_d = done;
  end

  task automatic clear_mon();
    rd_cnt = 0; wr_cnt = 0;
    first_rd = -1; first_wr = -1; last_wr = -1; done_t = -1;
  endtask

  task automatic start_pulse(input logic [7:0] off, input bit push);
    @(negedge clk);
    clear_mon();
    sb.delete();
    if (push) begin
      for (int k = 0; k < LEN; k++) sb.push_back('{8'(k), 8'(mem[k] + off)});
    end
    t0 = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; key_valid = 1'b0; ekey = '0; mod = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    total++; if ({rd_en, wr_en} !== 2'b00) begin bad++; $display("FAIL reset_en: got %b, required 00", {rd_en, wr_en}); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b, required 000", {busy, done, err}); end
    total++; if (progress !== 16'h0) begin bad++; $display("FAIL reset_progress: got %h, required 0000", progress); end
    total++; if ({rd_addr, wr_addr, wr_data} !== 24'h0) begin bad++; $display("FAIL reset_bus: got %h, required 0", {rd_addr, wr_addr, wr_data}); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    ekey = 8'd200; mod = 8'd7; key_valid = 1'b1;
    start_pulse(8'd4, 1'b1);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL nom_timeout: done never rose, required within 100 cycles"); end
    total++; if (first_rd !== t0 + 3) begin bad++; $display("FAIL nom_first_rd: got %0d, required %0d", first_rd, t0 + 3); end
    total++; if (first_wr !== t0 + 5) begin bad++; $display("FAIL nom_first_wr: got %0d, required %0d", first_wr, t0 + 5); end
    total++; if (last_wr !== t0 + 34) begin bad++; $display("FAIL nom_last_wr: got %0d, required %0d", last_wr, t0 + 34); end
    total++; if (done_t !== t0 + 35) begin bad++; $display("FAIL nom_done_t: got %0d, required %0d", done_t, t0 + 35); end
    total++; if (wr_cnt !== 30 || rd_cnt !== 30) begin bad++; $display("FAIL nom_counts: got wr=%0d rd=%0d, required 30/30", wr_cnt, rd_cnt); end
    total++; if (progress !== 16'hFFFF || busy !== 1'b0) begin bad++; $display("FAIL nom_final: got progress=%h busy=%b, required FFFF/0", progress, busy); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL nom_sb_left: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 8'(250 + k);
    ekey = 8'd9; mod = 8'd10; key_valid = 1'b1;
    start_pulse(8'd9, 1'b1);
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: done never rose, required within 100 cycles"); end
    total++; if (got[0] !== 8'd3 || got[5] !== 8'd8) begin bad++; $display("FAIL wrap_bytes: got b0=%0d b5=%0d, required 3/8", got[0], got[5]); end
    total++; if (wr_cnt !== 30 || sb.size() != 0) begin bad++; $display("FAIL wrap_count: got %0d writes %0d pending, required 30/0", wr_cnt, sb.size()); end
  endtask

  task automatic test_late_key();
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    ekey = 8'd200; mod = 8'd7; key_valid = 1'b0;
    start_pulse(8'd4, 1'b1);
    while (cyc < t0 + 8) @(negedge clk);
    total++; if (busy !== 1'b1 || rd_cnt !== 0) begin bad++; $display("FAIL late_wait: got busy=%b reads=%0d, required 1/0", busy, rd_cnt); end
    while (cyc < t0 + 13) @(negedge clk);
    key_valid = 1'b1;
    @(negedge clk);
    ekey = 8'd50;
    wait_done(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL late_timeout: done never rose, required within 100 cycles"); end
    total++; if (first_rd !== t0 + 15) begin bad++; $display("FAIL late_first_rd: got %0d, required %0d", first_rd, t0 + 15); end
    total++; if (done_t !== t0 + 47) begin bad++; $display("FAIL late_done_t: got %0d, required %0d", done_t, t0 + 47); end
    total++; if (wr_cnt !== 30 || sb.size() != 0) begin bad++; $display("FAIL late_count: got %0d writes %0d pending, required 30/0", wr_cnt, sb.size()); end
  endtask

  task automatic test_mod_zero();
    bit ok;
    ekey = 8'd200; mod = 8'd0; key_valid = 1'b1;
    start_pulse(8'd0, 1'b0);
    @(negedge clk);
    total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mz_calc: got err=%b busy=%b, required 0/1", err, busy); end
    @(negedge clk);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mz_err: got err=%b busy=%b, required 1/0", err, busy); end
    repeat (10) @(negedge clk);
    total++; if (rd_cnt !== 0 || wr_cnt !== 0) begin bad++; $display("FAIL mz_access: got rd=%0d wr=%0d, required 0/0", rd_cnt, wr_cnt); end
    total++; if (err !== 1'b1 || done !== 1'b0 || progress !== 16'h0) begin bad++; $display("FAIL mz_hold: got err=%b done=%b progress=%h, required 1/0/0000", err, done, progress); end
    mod = 8'd3;
    start_pulse(8'd2, 1'b1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mz_clear: got err=%b, required 0", err); end
    wait_done(100, ok);
    total++; if (!ok || done_t !== t0 + 35) begin bad++; $display("FAIL mz_rerun: got done at %0d, required %0d", done_t, t0 + 35); end
    total++; if (wr_cnt !== 30 || sb.size() != 0) begin bad++; $display("FAIL mz_count: got %0d writes %0d pending, required 30/0", wr_cnt, sb.size()); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int wr_at, rd_at;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    ekey = 8'd200; mod = 8'd7; key_valid = 1'b1;
    start_pulse(8'd4, 1'b1);
    for (int i = 0; i < 100 && wr_cnt < 10; i++) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++; if ({rd_en, wr_en, busy, done, err} !== 5'b0 || progress !== 16'h0) begin
      bad++; $display("FAIL mid_async: got en=%b%b flags=%b%b%b progress=%h, required all 0", rd_en, wr_en, busy, done, err, progress);
    end
    sb.delete();
    wr_at = wr_cnt; rd_at = rd_cnt;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (wr_cnt !== wr_at || rd_cnt !== rd_at) begin bad++; $display("FAIL mid_quiet: got wr=%0d rd=%0d, required %0d/%0d", wr_cnt, rd_cnt, wr_at, rd_at); end
    start_pulse(8'd4, 1'b1);
    wait_done(100, ok);
    total++; if (!ok || wr_cnt !== 30 || sb.size() != 0) begin bad++; $display("FAIL mid_rerun: got ok=%b writes=%0d pending=%0d, required 1/30/0", ok, wr_cnt, sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int k = 0; k < 256; k++) mem[k] = 8'(3 * k);
    ekey = 8'd200; mod = 8'd7; key_valid = 1'b1;
    start_pulse(8'd4, 1'b1);
    while (cyc < t0 + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, ok);
    total++; if (!ok || done_t !== t0 + 35) begin bad++; $display("FAIL busy_start_t: got done at %0d, required %0d", done_t, t0 + 35); end
    total++; if (wr_cnt !== 30 || first_rd !== t0 + 3) begin bad++; $display("FAIL busy_start_cnt: got wr=%0d first_rd=%0d, required 30/%0d", wr_cnt, first_rd, t0 + 3); end
    start_pulse(8'd4, 1'b1);
    total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL done_restart: got done=%b busy=%b, required 0/1", done, busy); end
    wait_done(100, ok);
    total++; if (!ok || done_t !== t0 + 35 || wr_cnt !== 30) begin bad++; $display("FAIL done_rerun: got done at %0d writes=%0d, required %0d/30", done_t, wr_cnt, t0 + 35); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_wrap();
    test_late_key();
    test_mod_zero();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
